// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU pipeline control logic: sequencer state
// encoding and register-index constants.
package cpu_ctrl_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    ST_RUN         = 2'd0,
    ST_IWAIT       = 2'd1,
    ST_IWAIT_REDIR = 2'd2,
    ST_DWAIT       = 2'd3
  } state_t;

  // True when a live source operand matches a writing destination other than r0.
  function automatic logic reg_match(input logic use_src,
                                     input logic [REG_W-1:0] src,
                                     input logic [REG_W-1:0] dst,
                                     input logic dst_we);
    return use_src & dst_we & (src == dst) & (dst != REG_ZERO);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational RAW / load-use comparator for the instruction in ID.
// With a forwarding network only loads in EX stall; otherwise any EX/MEM writer does.
module hazard_detect
  import cpu_ctrl_pkg::*;
#(
  parameter int FORWARD = 1
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             ex_regwrite,
  input  logic             mem_regwrite,
  input  logic             ex_memread,
  output logic             hazard
);

  logic w_ex_hit;
  logic w_mem_hit;

  assign w_ex_hit  = reg_match(id_use_rs, id_rs, ex_rd, ex_regwrite) |
                     reg_match(id_use_rt, id_rt, ex_rd, ex_regwrite);
  assign w_mem_hit = reg_match(id_use_rs, id_rs, mem_rd, mem_regwrite) |
                     reg_match(id_use_rt, id_rt, mem_rd, mem_regwrite);

  generate
    if (FORWARD != 0) begin : g_fwd
      assign hazard = w_ex_hit & ex_memread;
    end else begin : g_nofwd
      assign hazard = w_ex_hit | w_mem_hit;
    end
  endgenerate

endmodule

// File: rtl/hazard_ctrl.sv
// Central 5-stage pipeline sequencer: write-enable / flush control for PC and
// pipeline registers, pending-redirect holding across fetch waits, perf counters.
module hazard_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int FORWARD = 1,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             ex_regwrite,
  input  logic             mem_regwrite,
  input  logic             ex_memread,
  input  logic             ex_branch_taken,
  input  logic [31:0]      ex_target,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_we,
  output logic             pc_redirect,
  output logic [31:0]      pc_target,
  output logic             if_id_we,
  output logic             if_id_zero,
  output logic             id_ex_we,
  output logic             id_ex_zero,
  output logic             ex_mem_we,
  output logic             ex_mem_zero,
  output logic             mem_wb_we,
  output logic             mem_wb_zero,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_target;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_hazard;
  logic             w_dwait;
  logic             w_accept;
  logic             w_latch;

  hazard_detect #(
    .FORWARD(FORWARD)
  ) u_detect (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .ex_rd       (ex_rd),
    .mem_rd      (mem_rd),
    .ex_regwrite (ex_regwrite),
    .mem_regwrite(mem_regwrite),
    .ex_memread  (ex_memread),
    .hazard      (w_hazard)
  );

  assign w_dwait = dmem_req & ~dmem_ready;

  always_comb begin
    pc_we       = 1'b1;
    pc_redirect = 1'b0;
    pc_target   = ex_target;
    if_id_we    = 1'b1;
    if_id_zero  = 1'b0;
    id_ex_we    = 1'b1;
    id_ex_zero  = 1'b0;
    ex_mem_we   = 1'b1;
    ex_mem_zero = 1'b0;
    mem_wb_we   = 1'b1;
    mem_wb_zero = 1'b0;
    w_next      = r_state;
    w_accept    = 1'b0;
    w_latch     = 1'b0;

    if (!rst) begin
      if (w_dwait) begin
        // Whole front end frozen, so a taken branch in EX is simply re-presented later.
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        id_ex_we    = 1'b0;
        ex_mem_we   = 1'b0;
        mem_wb_zero = 1'b1;
        w_next      = (r_state == ST_IWAIT_REDIR) ? ST_IWAIT_REDIR : ST_DWAIT;
      end else if (r_state == ST_IWAIT_REDIR) begin
        // Younger path already squashed: further redirects and hazards are moot.
        if_id_zero = 1'b1;
        pc_target  = r_target;
        if (imem_ready) begin
          pc_redirect = 1'b1;
          w_next      = ST_RUN;
        end else begin
          pc_we = 1'b0;
        end
      end else if (ex_branch_taken) begin
        w_accept   = 1'b1;
        if_id_zero = 1'b1;
        id_ex_zero = 1'b1;
        if (imem_ready) begin
          pc_redirect = 1'b1;
          w_next      = ST_RUN;
        end else begin
          pc_we   = 1'b0;
          w_latch = 1'b1;
          w_next  = ST_IWAIT_REDIR;
        end
      end else if (!imem_ready) begin
        pc_we      = 1'b0;
        if_id_zero = 1'b1;
        w_next     = ST_IWAIT;
      end else begin
        w_next = ST_RUN;
        if (w_hazard) begin
          pc_we      = 1'b0;
          if_id_we   = 1'b0;
          id_ex_zero = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_target    <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_latch) begin
        r_target <= ex_target;
      end
      if (!pc_we) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_accept) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: one forwarding instance plus a
// non-forwarding instance for the RAW-stall cases.
module tb_hazard_ctrl;

  localparam logic [9:0] E_RUN = 10'b1010101010;
  localparam logic [9:0] E_LU  = 10'b0000111010;
  localparam logic [9:0] E_BR  = 10'b1111111010;
  localparam logic [9:0] E_BRW = 10'b0011111010;
  localparam logic [9:0] E_IW  = 10'b0011101010;
  localparam logic [9:0] E_IRR = 10'b1111101010;
  localparam logic [9:0] E_DW  = 10'b0000000011;

  logic        clk, rst;
  logic [4:0]  id_rs, id_rt, ex_rd, mem_rd;
  logic        id_use_rs, id_use_rt, ex_regwrite, mem_regwrite, ex_memread;
  logic        ex_branch_taken, imem_ready, dmem_req, dmem_ready;
  logic [31:0] ex_target;

  logic        pc_we, pc_redirect, if_id_we, if_id_zero, id_ex_we, id_ex_zero;
  logic        ex_mem_we, ex_mem_zero, mem_wb_we, mem_wb_zero;
  logic [31:0] pc_target, stall_cnt, flush_cnt;

  logic        n_pc_we, n_pc_redirect, n_if_id_we, n_if_id_zero, n_id_ex_we, n_id_ex_zero;
  logic        n_ex_mem_we, n_ex_mem_zero, n_mem_wb_we, n_mem_wb_zero;
  logic [31:0] n_pc_target, n_stall_cnt, n_flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [9:0]  q_exp[$];
  logic [31:0] q_tgt[$];

  hazard_ctrl #(.FORWARD(1), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_rd(ex_rd), .mem_rd(mem_rd),
    .ex_regwrite(ex_regwrite), .mem_regwrite(mem_regwrite), .ex_memread(ex_memread),
    .ex_branch_taken(ex_branch_taken), .ex_target(ex_target), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .pc_we(pc_we),
    .pc_redirect(pc_redirect), .pc_target(pc_target), .if_id_we(if_id_we),
    .if_id_zero(if_id_zero), .id_ex_we(id_ex_we), .id_ex_zero(id_ex_zero),
    .ex_mem_we(ex_mem_we), .ex_mem_zero(ex_mem_zero), .mem_wb_we(mem_wb_we),
    .mem_wb_zero(mem_wb_zero), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.FORWARD(0), .CNT_W(32)) dut_nf (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_rd(ex_rd), .mem_rd(mem_rd),
    .ex_regwrite(ex_regwrite), .mem_regwrite(mem_regwrite), .ex_memread(ex_memread),
    .ex_branch_taken(ex_branch_taken), .ex_target(ex_target), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .pc_we(n_pc_we),
    .pc_redirect(n_pc_redirect), .pc_target(n_pc_target), .if_id_we(n_if_id_we),
    .if_id_zero(n_if_id_zero), .id_ex_we(n_id_ex_we), .id_ex_zero(n_id_ex_zero),
    .ex_mem_we(n_ex_mem_we), .ex_mem_zero(n_ex_mem_zero), .mem_wb_we(n_mem_wb_we),
    .mem_wb_zero(n_mem_wb_zero), .stall_cnt(n_stall_cnt), .flush_cnt(n_flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] ctl_vec();
    return {pc_we, pc_redirect, if_id_we, if_id_zero, id_ex_we, id_ex_zero,
            ex_mem_we, ex_mem_zero, mem_wb_we, mem_wb_zero};
  endfunction

  function automatic logic [9:0] ctl_vec_nf();
    return {n_pc_we, n_pc_redirect, n_if_id_we, n_if_id_zero, n_id_ex_we, n_id_ex_zero,
            n_ex_mem_we, n_ex_mem_zero, n_mem_wb_we, n_mem_wb_zero};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    ex_rd = 0; mem_rd = 0; ex_regwrite = 0; mem_regwrite = 0; ex_memread = 0;
    ex_branch_taken = 0; ex_target = 0; imem_ready = 1; dmem_req = 0; dmem_ready = 0;
  endtask

  // Inputs already driven after the falling edge; expectation queued, checked, then one clock.
  task automatic step(input string tag, input logic [9:0] exp, input logic [31:0] tgt,
                      input logic chk_nf, input logic [9:0] exp_nf);
    logic [9:0]  e;
    logic [31:0] t;
    q_exp.push_back(exp);
    q_tgt.push_back(tgt);
    #2;
    e = q_exp.pop_front();
    t = q_tgt.pop_front();
    chk({tag, ".ctl"}, {22'd0, ctl_vec()}, {22'd0, e});
    if (e[8]) chk({tag, ".tgt"}, pc_target, t);
    if (chk_nf) chk({tag, ".nf_ctl"}, {22'd0, ctl_vec_nf()}, {22'd0, exp_nf});
    @(negedge clk);
  endtask

  initial begin
    clk = 0;
    rst = 1;
    idle();
    #3;
    chk("rst.ctl", {22'd0, ctl_vec()}, {22'd0, E_RUN});
    chk("rst.stall", stall_cnt, 0);
    chk("rst.flush", flush_cnt, 0);
    @(negedge clk);
    rst = 0;

    // Load-use on rs: one stall cycle, then the bubble has reached EX.
    ex_memread = 1; ex_regwrite = 1; ex_rd = 5; id_rs = 5; id_use_rs = 1;
    step("lu", E_LU, 0, 1, E_LU);
    chk("lu.stall", stall_cnt, 1);
    idle();
    step("lu_after", E_RUN, 0, 1, E_RUN);
    chk("lu_after.stall", stall_cnt, 1);

    // r0 never hazards.
    ex_memread = 1; ex_regwrite = 1; ex_rd = 0; id_rs = 0; id_use_rs = 1;
    step("lu_r0", E_RUN, 0, 1, E_RUN);
    idle();

    // MEM writer and EX ALU writer: stall only without forwarding.
    mem_regwrite = 1; mem_rd = 7; id_rt = 7; id_use_rt = 1;
    step("raw_mem", E_RUN, 0, 1, E_LU);
    idle();
    ex_regwrite = 1; ex_rd = 9; id_rs = 9; id_use_rs = 1;
    step("raw_ex", E_RUN, 0, 1, E_LU);
    idle();
    chk("nf.stall", n_stall_cnt, 3);
    chk("fwd.stall", stall_cnt, 1);

    // Redirect with fetch ready.
    ex_branch_taken = 1; ex_target = 32'h40;
    step("br", E_BR, 32'h40, 0, 0);
    chk("br.flush", flush_cnt, 1);
    idle();

    // Redirect during a fetch wait: target held, later branches ignored.
    ex_branch_taken = 1; ex_target = 32'h80; imem_ready = 0;
    step("brw", E_BRW, 0, 0, 0);
    chk("brw.flush", flush_cnt, 2);
    ex_branch_taken = 0; ex_target = 32'h0;
    step("iwr1", E_IW, 0, 0, 0);
    ex_branch_taken = 1; ex_target = 32'h100;
    step("iwr2", E_IW, 0, 0, 0);
    chk("iwr.stall", stall_cnt, 4);
    ex_branch_taken = 0; ex_target = 32'hDEAD; imem_ready = 1;
    step("iwr_go", E_IRR, 32'h80, 0, 0);
    chk("iwr_go.flush", flush_cnt, 2);
    idle();
    step("run2", E_RUN, 0, 0, 0);

    // Data wait with a pending branch: four frozen cycles, redirect on the fifth.
    dmem_req = 1; dmem_ready = 0; ex_branch_taken = 1; ex_target = 32'h200;
    for (int i = 0; i < 4; i++) step($sformatf("dw%0d", i), E_DW, 0, 0, 0);
    chk("dw.stall", stall_cnt, 8);
    chk("dw.flush", flush_cnt, 2);
    dmem_ready = 1;
    step("dw_br", E_BR, 32'h200, 0, 0);
    chk("dw_br.flush", flush_cnt, 3);
    idle();

    // Plain fetch wait, then redirect overriding a load-use stall.
    imem_ready = 0;
    step("fw", E_IW, 0, 0, 0);
    chk("fw.stall", stall_cnt, 9);
    idle();
    ex_memread = 1; ex_regwrite = 1; ex_rd = 3; id_rt = 3; id_use_rt = 1;
    ex_branch_taken = 1; ex_target = 32'h44;
    step("br_lu", E_BR, 32'h44, 0, 0);
    chk("br_lu.flush", flush_cnt, 4);
    idle();

    // Reset while a redirect is pending.
    ex_branch_taken = 1; ex_target = 32'h300; imem_ready = 0;
    step("brw2", E_BRW, 0, 0, 0);
    ex_branch_taken = 0;
    rst = 1;
    #1;
    chk("rst2.ctl", {22'd0, ctl_vec()}, {22'd0, E_RUN});
    chk("rst2.stall", stall_cnt, 0);
    chk("rst2.flush", flush_cnt, 0);
    @(negedge clk);
    rst = 0; imem_ready = 1; ex_target = 32'h0;
    step("rst2_run", E_RUN, 0, 0, 0);
    step("rst2_run2", E_RUN, 0, 0, 0);
    chk("rst2_run.stall", stall_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
